// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register for the five-stage MIPS core.
// Captures the ALU result/address and exception code, checks memory
// alignment, builds store byte enables and lane-replicated store data,
// and supports stall (hold) and flush (bubble) from the hazard unit.
// Optional build macro: ADDR_RANGE_CHECK_EN adds an address-window check
// (RAM 0x0000_0000..0x0000_2FFF, word-only MMIO 0x0000_7F00..0x0000_7F1B).
module ex_mem_stage #(
    parameter int         DATA_W   = 32,
    parameter logic [4:0] EXC_NONE = 5'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] ResultE,
    input  logic [4:0]        ExcCodeE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic              MemWriteE,
    input  logic              MemtoRegE,
    input  logic [1:0]        MemTypeE,
    input  logic              LoadSignedE,
    input  logic              RegWriteE,
    input  logic [4:0]        WriteRegE,
    input  logic [DATA_W-1:0] PCE,
    input  logic              BDE,
    output logic [DATA_W-1:0] ResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [3:0]        ByteEnM,
    output logic              MemReadM,
    output logic [1:0]        MemTypeM,
    output logic              LoadSignedM,
    output logic              RegWriteM,
    output logic [4:0]        WriteRegM,
    output logic [DATA_W-1:0] PCM,
    output logic              BDM,
    output logic [4:0]        ExcCodeM,
    output logic              ValidM
);

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_BYTE = 2'b10;

    logic [DATA_W-1:0] result_d, result_q;
    logic [DATA_W-1:0] write_data_d, write_data_q;
    logic [3:0]        byte_en_d, byte_en_q;
    logic              mem_read_d, mem_read_q;
    logic [1:0]        mem_type_d, mem_type_q;
    logic              load_signed_d, load_signed_q;
    logic              reg_write_d, reg_write_q;
    logic [4:0]        write_reg_d, write_reg_q;
    logic [DATA_W-1:0] pc_d, pc_q;
    logic              bd_d, bd_q;
    logic [4:0]        exc_code_d, exc_code_q;
    logic              valid_d, valid_q;

    logic              misaligned;
    logic              addr_fault;
    logic [3:0]        lane_en;
    logic [DATA_W-1:0] store_data;
    logic [4:0]        addr_code;
    logic [4:0]        final_code;
    logic              suppress;

`ifdef ADDR_RANGE_CHECK_EN
    logic              is_word;
    logic              in_ram;
    logic              in_mmio;
`endif

    // E-side decode: alignment, byte lanes, store data and final exception code
    always_comb begin
        misaligned = 1'b0;
        lane_en    = 4'b1111;
        store_data = WriteDataE;
        case (MemTypeE)
            MEM_HALF: begin
                misaligned = ResultE[0];
                lane_en    = ResultE[1] ? 4'b1100 : 4'b0011;
                store_data = {WriteDataE[15:0], WriteDataE[15:0]};
            end
            MEM_BYTE: begin
                misaligned = 1'b0;
                lane_en    = 4'b0001 << ResultE[1:0];
                store_data = {4{WriteDataE[7:0]}};
            end
            default: begin
                misaligned = |ResultE[1:0];
                lane_en    = 4'b1111;
                store_data = WriteDataE;
            end
        endcase

`ifdef ADDR_RANGE_CHECK_EN
        is_word    = (MemTypeE != MEM_HALF) && (MemTypeE != MEM_BYTE);
        in_ram     = (ResultE <= 32'h0000_2FFF);
        in_mmio    = (ResultE >= 32'h0000_7F00) && (ResultE <= 32'h0000_7F1B);
        addr_fault = misaligned || !(in_ram || (in_mmio && is_word));
`else
        addr_fault = misaligned;
`endif

        addr_code = EXC_NONE;
        if ((MemWriteE || MemtoRegE) && addr_fault) begin
            addr_code = MemWriteE ? EXC_ADES : EXC_ADEL;
        end

        final_code = (ExcCodeE != EXC_NONE) ? ExcCodeE : addr_code;
        suppress   = (final_code != EXC_NONE);
    end

    // Next-state for the M-stage registers: flush beats stall beats load
    always_comb begin
        result_d      = result_q;
        write_data_d  = write_data_q;
        byte_en_d     = byte_en_q;
        mem_read_d    = mem_read_q;
        mem_type_d    = mem_type_q;
        load_signed_d = load_signed_q;
        reg_write_d   = reg_write_q;
        write_reg_d   = write_reg_q;
        pc_d          = pc_q;
        bd_d          = bd_q;
        exc_code_d    = exc_code_q;
        valid_d       = valid_q;
        if (flush) begin
            result_d      = '0;
            write_data_d  = '0;
            byte_en_d     = '0;
            mem_read_d    = 1'b0;
            mem_type_d    = '0;
            load_signed_d = 1'b0;
            reg_write_d   = 1'b0;
            write_reg_d   = '0;
            pc_d          = '0;
            bd_d          = 1'b0;
            exc_code_d    = EXC_NONE;
            valid_d       = 1'b0;
        end else if (!stall) begin
            result_d      = ResultE;
            write_data_d  = store_data;
            byte_en_d     = (MemWriteE && !suppress) ? lane_en : 4'b0000;
            mem_read_d    = MemtoRegE && !suppress;
            mem_type_d    = MemTypeE;
            load_signed_d = LoadSignedE;
            reg_write_d   = RegWriteE && !suppress;
            write_reg_d   = WriteRegE;
            pc_d          = PCE;
            bd_d          = BDE;
            exc_code_d    = final_code;
            valid_d       = 1'b1;
        end
    end

    // M-stage state registers, cleared to a bubble by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q      <= '0;
            write_data_q  <= '0;
            byte_en_q     <= '0;
            mem_read_q    <= 1'b0;
            mem_type_q    <= '0;
            load_signed_q <= 1'b0;
            reg_write_q   <= 1'b0;
            write_reg_q   <= '0;
            pc_q          <= '0;
            bd_q          <= 1'b0;
            exc_code_q    <= EXC_NONE;
            valid_q       <= 1'b0;
        end else begin
            result_q      <= result_d;
            write_data_q  <= write_data_d;
            byte_en_q     <= byte_en_d;
            mem_read_q    <= mem_read_d;
            mem_type_q    <= mem_type_d;
            load_signed_q <= load_signed_d;
            reg_write_q   <= reg_write_d;
            write_reg_q   <= write_reg_d;
            pc_q          <= pc_d;
            bd_q          <= bd_d;
            exc_code_q    <= exc_code_d;
            valid_q       <= valid_d;
        end
    end

    assign ResultM     = result_q;
    assign WriteDataM  = write_data_q;
    assign ByteEnM     = byte_en_q;
    assign MemReadM    = mem_read_q;
    assign MemTypeM    = mem_type_q;
    assign LoadSignedM = load_signed_q;
    assign RegWriteM   = reg_write_q;
    assign WriteRegM   = write_reg_q;
    assign PCM         = pc_q;
    assign BDM         = bd_q;
    assign ExcCodeM    = exc_code_q;
    assign ValidM      = valid_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: table of single-instruction vectors plus
// hand-written stall/flush/async-reset sequences, with expected M-stage
// outputs queued when stimulus is driven and popped after the clock edge.
module tb_ex_mem_stage;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] wdata;
        logic        mem_write;
        logic        mem_to_reg;
        logic [1:0]  mem_type;
        logic        load_signed;
        logic        reg_write;
        logic [4:0]  write_reg;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
    } in_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] wdata;
        logic [3:0]  byte_en;
        logic        mem_read;
        logic [1:0]  mem_type;
        logic        load_signed;
        logic        reg_write;
        logic [4:0]  write_reg;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        valid;
    } out_t;

    typedef struct packed {
        in_t         stim;
        logic [3:0]  byte_en;
        logic [31:0] wdata;
        logic [4:0]  exc;
        logic        mem_read;
        logic        reg_write;
    } vec_t;

    localparam int NUM_VECS = 18;

`ifdef ADDR_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] ResultE;
    logic [4:0]  ExcCodeE;
    logic [31:0] WriteDataE;
    logic        MemWriteE;
    logic        MemtoRegE;
    logic [1:0]  MemTypeE;
    logic        LoadSignedE;
    logic        RegWriteE;
    logic [4:0]  WriteRegE;
    logic [31:0] PCE;
    logic        BDE;
    logic [31:0] ResultM;
    logic [31:0] WriteDataM;
    logic [3:0]  ByteEnM;
    logic        MemReadM;
    logic [1:0]  MemTypeM;
    logic        LoadSignedM;
    logic        RegWriteM;
    logic [4:0]  WriteRegM;
    logic [31:0] PCM;
    logic        BDM;
    logic [4:0]  ExcCodeM;
    logic        ValidM;

    int   tests_run;
    int   tests_failed;
    out_t exp_q[$];
    vec_t vecs[NUM_VECS];

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ResultE(ResultE), .ExcCodeE(ExcCodeE), .WriteDataE(WriteDataE),
        .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .MemTypeE(MemTypeE),
        .LoadSignedE(LoadSignedE), .RegWriteE(RegWriteE), .WriteRegE(WriteRegE),
        .PCE(PCE), .BDE(BDE),
        .ResultM(ResultM), .WriteDataM(WriteDataM), .ByteEnM(ByteEnM),
        .MemReadM(MemReadM), .MemTypeM(MemTypeM), .LoadSignedM(LoadSignedM),
        .RegWriteM(RegWriteM), .WriteRegM(WriteRegM), .PCM(PCM), .BDM(BDM),
        .ExcCodeM(ExcCodeM), .ValidM(ValidM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk_vec(
        input logic [31:0] res, input logic [31:0] wd,
        input logic mw, input logic mr, input logic [1:0] mt,
        input logic ls, input logic rw, input logic [4:0] wr,
        input logic [4:0] exc_in, input logic [3:0] be,
        input logic [31:0] wdm, input logic [4:0] excm,
        input logic mrd, input logic rwm);
        vec_t v;
        v.stim.result      = res;
        v.stim.wdata       = wd;
        v.stim.mem_write   = mw;
        v.stim.mem_to_reg  = mr;
        v.stim.mem_type    = mt;
        v.stim.load_signed = ls;
        v.stim.reg_write   = rw;
        v.stim.write_reg   = wr;
        v.stim.pc          = 32'h0;
        v.stim.bd          = 1'b0;
        v.stim.exc         = exc_in;
        v.byte_en          = be;
        v.wdata            = wdm;
        v.exc              = excm;
        v.mem_read         = mrd;
        v.reg_write        = rwm;
        return v;
    endfunction

    function automatic out_t expect_of(input vec_t v);
        out_t o;
        o.result      = v.stim.result;
        o.wdata       = v.wdata;
        o.byte_en     = v.byte_en;
        o.mem_read    = v.mem_read;
        o.mem_type    = v.stim.mem_type;
        o.load_signed = v.stim.load_signed;
        o.reg_write   = v.reg_write;
        o.write_reg   = v.stim.write_reg;
        o.pc          = v.stim.pc;
        o.bd          = v.stim.bd;
        o.exc         = v.exc;
        o.valid       = 1'b1;
        return o;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare every M-stage output against it
    task automatic compare_outputs(input string tag);
        out_t e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check_val({tag, ".ResultM"},     ResultM,     e.result);
        check_val({tag, ".WriteDataM"},  WriteDataM,  e.wdata);
        check_val({tag, ".ByteEnM"},     {28'd0, ByteEnM},   {28'd0, e.byte_en});
        check_val({tag, ".MemReadM"},    {31'd0, MemReadM},  {31'd0, e.mem_read});
        check_val({tag, ".MemTypeM"},    {30'd0, MemTypeM},  {30'd0, e.mem_type});
        check_val({tag, ".LoadSignedM"}, {31'd0, LoadSignedM}, {31'd0, e.load_signed});
        check_val({tag, ".RegWriteM"},   {31'd0, RegWriteM}, {31'd0, e.reg_write});
        check_val({tag, ".WriteRegM"},   {27'd0, WriteRegM}, {27'd0, e.write_reg});
        check_val({tag, ".PCM"},         PCM,         e.pc);
        check_val({tag, ".BDM"},         {31'd0, BDM},       {31'd0, e.bd});
        check_val({tag, ".ExcCodeM"},    {27'd0, ExcCodeM},  {27'd0, e.exc});
        check_val({tag, ".ValidM"},      {31'd0, ValidM},    {31'd0, e.valid});
    endtask

    task automatic apply_stimulus(input in_t s, input logic st, input logic fl, input out_t exp);
        @(negedge clk);
        ResultE     = s.result;
        WriteDataE  = s.wdata;
        MemWriteE   = s.mem_write;
        MemtoRegE   = s.mem_to_reg;
        MemTypeE    = s.mem_type;
        LoadSignedE = s.load_signed;
        RegWriteE   = s.reg_write;
        WriteRegE   = s.write_reg;
        PCE         = s.pc;
        BDE         = s.bd;
        ExcCodeE    = s.exc;
        stall       = st;
        flush       = fl;
        exp_q.push_back(exp);
    endtask

    task automatic check_output(input string tag);
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    initial begin
        out_t bubble;
        out_t held;
        tests_run    = 0;
        tests_failed = 0;
        bubble       = '0;

        vecs[0]  = mk_vec(32'h10,   32'hDEADBEEF, 1, 0, 2'b00, 0, 0, 5'd0,  5'd0,  4'b1111, 32'hDEADBEEF, 5'd0,  0, 0);
        vecs[1]  = mk_vec(32'h13,   32'h000000AB, 1, 0, 2'b10, 0, 0, 5'd0,  5'd0,  4'b1000, 32'hABABABAB, 5'd0,  0, 0);
        vecs[2]  = mk_vec(32'h1,    32'h12345678, 0, 1, 2'b01, 1, 1, 5'd8,  5'd0,  4'b0000, 32'h56785678, 5'd4,  0, 0);
        vecs[3]  = mk_vec(32'h2,    32'h01020304, 1, 0, 2'b00, 0, 0, 5'd0,  5'd12, 4'b0000, 32'h01020304, 5'd12, 0, 0);
        vecs[4]  = mk_vec(32'h2,    32'hCAFEBABE, 1, 0, 2'b01, 0, 0, 5'd0,  5'd0,  4'b1100, 32'hBABEBABE, 5'd0,  0, 0);
        vecs[5]  = mk_vec(32'h100,  32'hCAFEBABE, 1, 0, 2'b01, 0, 0, 5'd0,  5'd0,  4'b0011, 32'hBABEBABE, 5'd0,  0, 0);
        vecs[6]  = mk_vec(32'h20,   32'h00000000, 0, 1, 2'b00, 0, 1, 5'd9,  5'd0,  4'b0000, 32'h00000000, 5'd0,  1, 1);
        vecs[7]  = mk_vec(32'h7,    32'h11223344, 0, 1, 2'b10, 1, 1, 5'd10, 5'd0,  4'b0000, 32'h44444444, 5'd0,  1, 1);
        vecs[8]  = mk_vec(32'h3,    32'h00000055, 0, 0, 2'b00, 0, 1, 5'd11, 5'd0,  4'b0000, 32'h00000055, 5'd0,  0, 1);
        vecs[9]  = mk_vec(32'h1,    32'hFFFF0000, 1, 1, 2'b00, 0, 1, 5'd12, 5'd0,  4'b0000, 32'hFFFF0000, 5'd5,  0, 0);
        vecs[10] = mk_vec(32'h2,    32'h00000009, 1, 0, 2'b11, 0, 0, 5'd0,  5'd0,  4'b0000, 32'h00000009, 5'd5,  0, 0);
        vecs[11] = mk_vec(32'h4,    32'h89ABCDEF, 1, 0, 2'b11, 0, 0, 5'd0,  5'd0,  4'b1111, 32'h89ABCDEF, 5'd0,  0, 0);
        vecs[12] = mk_vec(32'h2001, 32'h00000077, 1, 0, 2'b10, 0, 0, 5'd0,  5'd0,  4'b0010, 32'h77777777, 5'd0,  0, 0);
        vecs[13] = mk_vec(32'h2FFE, 32'h00000066, 1, 0, 2'b10, 0, 0, 5'd0,  5'd0,  4'b0100, 32'h66666666, 5'd0,  0, 0);
        vecs[14] = mk_vec(32'h8,    32'h00000000, 0, 0, 2'b00, 0, 1, 5'd3,  5'd12, 4'b0000, 32'h00000000, 5'd12, 0, 0);
        vecs[15] = mk_vec(32'h4000, 32'h00000000, 0, 1, 2'b00, 0, 1, 5'd4,  5'd0,  4'b0000, 32'h00000000,
                          RC ? 5'd4 : 5'd0, !RC, !RC);
        vecs[16] = mk_vec(32'h7F00, 32'h0000BEEF, 0, 1, 2'b01, 1, 1, 5'd5,  5'd0,  4'b0000, 32'hBEEFBEEF,
                          RC ? 5'd4 : 5'd0, !RC, !RC);
        vecs[17] = mk_vec(32'h7F18, 32'h13572468, 1, 0, 2'b00, 0, 0, 5'd0,  5'd0,  4'b1111, 32'h13572468, 5'd0,  0, 0);
        for (int i = 0; i < NUM_VECS; i++) begin
            vecs[i].stim.pc = 32'h0040_0000 + 32'(i * 4);
            vecs[i].stim.bd = i[0];
        end

        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        ResultE = '0; ExcCodeE = '0; WriteDataE = '0; MemWriteE = 1'b0;
        MemtoRegE = 1'b0; MemTypeE = '0; LoadSignedE = 1'b0; RegWriteE = 1'b0;
        WriteRegE = '0; PCE = '0; BDE = 1'b0;

        #2;
        exp_q.push_back(bubble);
        compare_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vecs[i].stim, 1'b0, 1'b0, expect_of(vecs[i]));
            check_output($sformatf("vec%0d", i));
        end

        // Stall holds the previous contents for three cycles of changing inputs
        held = expect_of(vecs[0]);
        apply_stimulus(vecs[0].stim, 1'b0, 1'b0, held);
        check_output("stall_load");
        for (int k = 1; k <= 3; k++) begin
            apply_stimulus(vecs[k + 5].stim, 1'b1, 1'b0, held);
            check_output($sformatf("stall%0d", k));
        end
        apply_stimulus(vecs[7].stim, 1'b1, 1'b1, bubble);
        check_output("stall_flush");
        apply_stimulus(vecs[1].stim, 1'b0, 1'b0, expect_of(vecs[1]));
        check_output("after_flush");

        // Asynchronous reset between edges while the stage holds a valid instruction
        apply_stimulus(vecs[6].stim, 1'b0, 1'b0, expect_of(vecs[6]));
        check_output("pre_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(bubble);
        compare_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while stalled
        apply_stimulus(vecs[4].stim, 1'b0, 1'b0, expect_of(vecs[4]));
        check_output("pre_stall_reset");
        @(negedge clk);
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(bubble);
        compare_outputs("stall_reset");
        @(posedge clk);
        #1;
        exp_q.push_back(bubble);
        compare_outputs("stall_reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
EX→MEM pipeline stage of the five-stage MIPS core. Sits directly downstream of the execute ALU and captures the ALU result (the effective address for loads and stores) and the ALU's exception code. It performs the memory-alignment check and byte-enable/store-data lane generation, then registers everything for the MEM stage. Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- EXC_NONE, 0, ExcCode value meaning "no exception".

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all M-stage registers.
- flush  in  1  load a bubble into the M stage.
- ResultE  in  32  ALU result / effective address.
- ExcCodeE  in  5  exception code from the ALU.
- WriteDataE  in  32  forwarded rt value to store.
- MemWriteE  in  1  store instruction.
- MemtoRegE  in  1  load instruction.
- MemTypeE  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- LoadSignedE  in  1  sign-extend on load.
- RegWriteE  in  1  writes the register file.
- WriteRegE  in  5  destination register.
- PCE  in  32  instruction PC.
- BDE  in  1  instruction is in a branch delay slot.
- ResultM  out  32  registered address/result.
- WriteDataM  out  32  store data replicated into byte lanes.
- ByteEnM  out  4  store byte enables; 0 when no store is performed.
- MemReadM  out  1  qualified load.
- MemTypeM  out  2  registered size.
- LoadSignedM  out  1  registered sign flag.
- RegWriteM  out  1  qualified register write.
- WriteRegM  out  5  registered destination.
- PCM  out  32  registered PC.
- BDM  out  1  registered delay-slot flag.
- ExcCodeM  out  5  final exception code.
- ValidM  out  1  the M stage holds a real instruction (not a bubble).

Behaviour:
- Reset (rst_n=0, async): every output is 0, ValidM=0, ExcCodeM=EXC_NONE. The stage is a bubble immediately and no clock edge is needed. Reset asserted mid-stall also clears the stage.
- Latency: one cycle. Values presented in E at edge N appear on the M outputs after edge N.
- Priority at each edge: flush > stall > normal load.
  - flush: load a bubble. All control outputs 0, ExcCodeM=EXC_NONE, ValidM=0, data outputs 0.
  - stall (flush=0): every register holds its value.
  - normal: load E-side values, ValidM=1.
- Alignment check, combinational on the E side and registered:
  - word: misaligned if ResultE[1:0]≠0.
  - half: misaligned if ResultE[0]≠0.
  - byte: never misaligned.
  - The check applies only when MemWriteE or MemtoRegE is set.
  - A misaligned load gives code 4 (AdEL); a misaligned store gives code 5 (AdES).
- Exception priority: if ExcCodeE≠EXC_NONE, ExcCodeM=ExcCodeE and the alignment result is ignored, because the earlier exception wins. Otherwise ExcCodeM is the alignment code or EXC_NONE.
- Suppression: if the final code is not EXC_NONE, then ByteEnM=0, MemReadM=0 and RegWriteM=0. PCM, BDM and ResultM are still captured for EPC/BadVAddr.
- Byte enables, when the store is not suppressed (a = ResultE[1:0]):
  - word: 1111.
  - half: 0011 if a[1]=0, else 1100.
  - byte: 0001 shifted left by a.
- Store data:
  - word: as-is.
  - half: {WriteDataE[15:0], WriteDataE[15:0]}.
  - byte: WriteDataE[7:0] replicated into all four lanes.
- MemReadM = MemtoRegE and not suppressed.
- If MemWriteE and MemtoRegE are both 1 (illegal), the store is treated as taking precedence in the exception code. Both qualified outputs follow the suppression rule.

Optional Feature:
- Macro: ADDR_RANGE_CHECK_EN.
- Defined: a load or store that is aligned but whose address is outside [0x0000_0000, 0x0000_2FFF] and outside [0x0000_7F00, 0x0000_7F1B] raises 4 (load) or 5 (store). This has the same priority and suppression as a misalignment.
  - Within the second window, only word accesses are legal; half and byte accesses raise 4/5.
- Undefined: no range check; only alignment is checked.

Test Plan:
- Word store, ResultE=0x0000_0010, WriteDataE=0xDEADBEEF, one edge → ByteEnM=1111, WriteDataM=0xDEADBEEF, ExcCodeM=0, ValidM=1.
- Byte store, ResultE=0x0000_0013, WriteDataE=0x0000_00AB → ByteEnM=1000, WriteDataM=0xABABABAB.
- Half load, ResultE=0x0000_0001, RegWriteE=1 → ExcCodeM=4, MemReadM=0, RegWriteM=0, ResultM=0x0000_0001.
- ExcCodeE=12 with a misaligned word store → ExcCodeM=12, ByteEnM=0.
- Load valid data, then stall=1 for 3 cycles with changing inputs → outputs are unchanged. Then stall=1 and flush=1 together → bubble: ValidM=0, all outputs 0.
- Drop rst_n asynchronously between edges while ValidM=1 → all outputs 0 immediately. With ADDR_RANGE_CHECK_EN, a word load at 0x0000_4000 → ExcCodeM=4.
